// File: rtl/pe_pkg.sv
// Shared types and helpers for the output-stationary MAC processing element.
// Holds the tile FSM encoding, product width and accumulator clamp bounds.
package pe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_e;

  localparam int PROD_FACTOR = 2;
  localparam int MAX_W       = 128;

  function automatic int prod_width(input int data_w);
    return PROD_FACTOR * data_w;
  endfunction

  // Bounds are returned wide; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] sat_max(input int w, input bit is_signed);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return is_signed ? (one << (w - 1)) - one : (one << w) - one;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w, input bit is_signed);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return is_signed ? (one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational accumulator adder with optional clamp to the signed or
// unsigned range of W bits; ovf reports that a clamp was applied.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int W      = 36,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] HI = W'(sat_max(W, SIGNED != 0));
  localparam logic [W-1:0] LO = W'(sat_min(W, SIGNED != 0));

  logic [W:0] raw;
  logic       wrap_ovf;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    // Signed overflow: operands agree in sign but the result does not.
    if (SIGNED != 0) wrap_ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    else             wrap_ovf = raw[W];
    sum = raw[W-1:0];
    ovf = 1'b0;
    if ((SAT != 0) && wrap_ovf) begin
      ovf = 1'b1;
      sum = ((SIGNED != 0) && b[W-1]) ? LO : HI;
    end
  end

endmodule

// File: rtl/pe_mac_os.sv
// Output-stationary MAC PE: forwards act/weight, multiplies valid pairs and
// accumulates k_len products per tile, emitting each tile result as a pulse.
module pe_mac_os
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 36,
  parameter int K_W    = 8,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] act_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic [K_W-1:0]    k_len,
  output logic [DATA_W-1:0] act_out,
  output logic [DATA_W-1:0] w_out,
  output logic              out_valid,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic              sat_flag,
  output logic              busy,
  output pe_state_e         fsm_state
);

  // Handshake: there is no ready. in_valid qualifies act_in/w_in on every
  // en=1 edge; sum_valid holds while en=0, so consumers qualify it with en.

  localparam int PROD_W = prod_width(DATA_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out   <= '0;
      w_out     <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      act_out   <= '0;
      w_out     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      act_out   <= act_in;
      w_out     <= w_in;
      out_valid <= in_valid;
    end
  end

  logic signed [PROD_W-1:0] a_s, w_s;
  logic        [PROD_W-1:0] prod_d, prod_q;
  logic                     p_valid, p_last, last_d;

  always_comb begin
    a_s = PROD_W'($signed(act_in));
    w_s = PROD_W'($signed(w_in));
    if (SIGNED != 0) prod_d = a_s * w_s;
    else             prod_d = PROD_W'(act_in) * PROD_W'(w_in);
  end

  pe_state_e          state_q, state_d;
  logic [K_W-1:0]     k_lat_q, k_lat_d, cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    k_lat_d = k_lat_q;
    cnt_d   = cnt_q;
    last_d  = 1'b0;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          // k_len of 0 is treated as a single-product tile.
          k_lat_d = (k_len == '0) ? K_W'(1) : k_len;
          cnt_d   = K_W'(1);
          if (k_len <= K_W'(1)) last_d = 1'b1;
          else                  state_d = ACC;
        end
        ACC: begin
          if (cnt_q == k_lat_q - K_W'(1)) begin
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + K_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_lat_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      k_lat_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      k_lat_q <= k_lat_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      p_valid <= in_valid;
      p_last  <= last_d;
    end
  end

  logic [ACC_W-1:0] prod_ext, acc_q, acc_sum;
  logic             sticky_q, acc_ovf, tile_done;

  always_comb begin
    if (SIGNED != 0) prod_ext = ACC_W'($signed(prod_q));
    else             prod_ext = ACC_W'(prod_q);
  end

  pe_sat_add #(
    .W      (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  assign tile_done = en && p_valid && p_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      sum_valid <= 1'b0;
    end else if (clr) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      sum_valid <= 1'b0;
    end else if (en) begin
      sum_valid <= tile_done;
      if (p_valid && p_last) begin
        acc_q    <= '0;
        sticky_q <= 1'b0;
      end else if (p_valid) begin
        acc_q    <= acc_sum;
        sticky_q <= sticky_q | acc_ovf;
      end
    end
  end

  // Result registers survive clr so the last completed tile stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out  <= '0;
      sat_flag <= 1'b0;
    end else if (!clr && tile_done) begin
      sum_out  <= acc_sum;
      sat_flag <= sticky_q | acc_ovf;
    end
  end

  assign busy      = (state_q == ACC) | p_valid;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pe_mac_os.sv
// Bench for pe_mac_os: four configurations share one stimulus stream and are
// checked against a per-tile arithmetic reference through expected queues.
module tb_pe_mac_os;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, in_valid = 1'b0;
  logic [15:0] act_in = '0, w_in = '0;
  logic [7:0]  k_len = '0;

  logic [15:0] act_out0, w_out0;
  logic        out_valid0, sv0, sf0, busy0;
  logic [35:0] sum0;
  pe_state_e   st0;

  logic [7:0]  act_out1, w_out1, act_out2, w_out2, act_out3, w_out3;
  logic        out_valid1, out_valid2, out_valid3;
  logic [15:0] sum1, sum2, sum3;
  logic        sv1, sv2, sv3, sf1, sf2, sf3, busy1, busy2, busy3;
  pe_state_e   st1, st2, st3;

  always #5 clk = ~clk;

  pe_mac_os #(.DATA_W(16), .ACC_W(36), .K_W(8), .SIGNED(1), .SAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
    .act_in(act_in), .w_in(w_in), .k_len(k_len),
    .act_out(act_out0), .w_out(w_out0), .out_valid(out_valid0),
    .sum_out(sum0), .sum_valid(sv0), .sat_flag(sf0), .busy(busy0), .fsm_state(st0));

  pe_mac_os #(.DATA_W(8), .ACC_W(16), .K_W(8), .SIGNED(1), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
    .act_in(act_in[7:0]), .w_in(w_in[7:0]), .k_len(k_len),
    .act_out(act_out1), .w_out(w_out1), .out_valid(out_valid1),
    .sum_out(sum1), .sum_valid(sv1), .sat_flag(sf1), .busy(busy1), .fsm_state(st1));

  pe_mac_os #(.DATA_W(8), .ACC_W(16), .K_W(8), .SIGNED(1), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
    .act_in(act_in[7:0]), .w_in(w_in[7:0]), .k_len(k_len),
    .act_out(act_out2), .w_out(w_out2), .out_valid(out_valid2),
    .sum_out(sum2), .sum_valid(sv2), .sat_flag(sf2), .busy(busy2), .fsm_state(st2));

  pe_mac_os #(.DATA_W(8), .ACC_W(16), .K_W(8), .SIGNED(0), .SAT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid),
    .act_in(act_in[7:0]), .w_in(w_in[7:0]), .k_len(k_len),
    .act_out(act_out3), .w_out(w_out3), .out_valid(out_valid3),
    .sum_out(sum3), .sum_valid(sv3), .sat_flag(sf3), .busy(busy3), .fsm_state(st3));

  int total = 0;
  int bad   = 0;

  int cfg_dw [4] = '{16, 8, 8, 8};
  int cfg_aw [4] = '{36, 16, 16, 16};
  int cfg_sg [4] = '{1, 1, 1, 0};
  int cfg_sat[4] = '{1, 1, 0, 1};

  // Reference state: tile progress, per-config running sums, pending result.
  int          m_k, m_cnt;
  longint      m_acc [4];
  bit          m_flag[4];
  bit          pend;
  logic [36:0] pend_val [4];
  logic [36:0] last_seen[4];
  bit          m_pvalid, m_ov;
  logic [15:0] m_act, m_w;

  logic [36:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int q_size(input int id);
    case (id)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic void q_push(input int id, input logic [36:0] v);
    case (id)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      2: exp_q2.push_back(v);
      default: exp_q3.push_back(v);
    endcase
  endfunction

  function automatic logic [36:0] q_pop(input int id);
    case (id)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      2: return exp_q2.pop_front();
      default: return exp_q3.pop_front();
    endcase
  endfunction

  function automatic longint operand(input int id, input logic [15:0] v);
    if (cfg_dw[id] == 16) return (cfg_sg[id] != 0) ? longint'($signed(v)) : longint'(v);
    return (cfg_sg[id] != 0) ? longint'($signed(v[7:0])) : longint'(v[7:0]);
  endfunction

  // Add one product with plain integer arithmetic, then clamp or wrap.
  function automatic void model_add(input int id, input longint p);
    longint one, lo, hi, span, t;
    one  = 1;
    span = one << cfg_aw[id];
    if (cfg_sg[id] != 0) begin
      hi = (one << (cfg_aw[id] - 1)) - 1;
      lo = -(one << (cfg_aw[id] - 1));
    end else begin
      hi = span - 1;
      lo = 0;
    end
    t = m_acc[id] + p;
    if (cfg_sat[id] != 0) begin
      if (t > hi) begin t = hi; m_flag[id] = 1'b1; end
      if (t < lo) begin t = lo; m_flag[id] = 1'b1; end
    end else begin
      t = (((t - lo) % span) + span) % span + lo;
    end
    m_acc[id] = t;
  endfunction

  function automatic logic [36:0] pack(input int id);
    logic [63:0] u, mask;
    mask = (64'd1 << cfg_aw[id]) - 64'd1;
    u    = 64'(m_acc[id]) & mask;
    return 37'(u) | (37'(m_flag[id]) << cfg_aw[id]);
  endfunction

  function automatic void tile_reset();
    m_cnt = 0;
    for (int id = 0; id < 4; id++) begin
      m_acc[id]  = 0;
      m_flag[id] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    tile_reset();
    m_k = 0; pend = 1'b0; m_pvalid = 1'b0; m_ov = 1'b0; m_act = '0; m_w = '0;
    for (int id = 0; id < 4; id++) last_seen[id] = '0;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (clr) begin
      tile_reset();
      pend = 1'b0; m_pvalid = 1'b0; m_ov = 1'b0; m_act = '0; m_w = '0;
    end else if (en) begin
      if (pend) for (int id = 0; id < 4; id++) q_push(id, pend_val[id]);
      pend = 1'b0;
      m_act = act_in; m_w = w_in; m_ov = in_valid; m_pvalid = in_valid;
      if (in_valid) begin
        if (m_cnt == 0) m_k = (k_len == 8'd0) ? 1 : int'(k_len);
        for (int id = 0; id < 4; id++) model_add(id, operand(id, act_in) * operand(id, w_in));
        m_cnt++;
        if (m_cnt == m_k) begin
          pend = 1'b1;
          for (int id = 0; id < 4; id++) pend_val[id] = pack(id);
          tile_reset();
        end
      end
    end
  endfunction

  task automatic beat(input logic e, input logic c, input logic v,
                      input logic [15:0] a, input logic [15:0] w, input logic [7:0] k);
    en = e; clr = c; in_valid = v; act_in = a; w_in = w; k_len = k;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
  endtask

  task automatic mon(input int id, input logic sv, input logic [36:0] got);
    logic [36:0] e;
    if (sv && en) begin
      if (q_size(id) == 0) begin
        check($sformatf("unexpected_pulse_dut%0d", id), 64'(got), 64'h1_0000_0000_0000);
      end else begin
        e = q_pop(id);
        check($sformatf("result_dut%0d", id), 64'(got), 64'(e));
        last_seen[id] = e;
      end
    end else if (!sv) begin
      check($sformatf("hold_dut%0d", id), 64'(got), 64'(last_seen[id]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("fwd_act0", 64'(act_out0), 64'(m_act));
      check("fwd_w0", 64'(w_out0), 64'(m_w));
      check("fwd_valid0", 64'(out_valid0), 64'(m_ov));
      check("fwd_act1", 64'(act_out1), 64'(m_act[7:0]));
      check("busy0", 64'(busy0), 64'((m_cnt > 0) || m_pvalid));
      check("state0", 64'(st0), 64'((m_cnt > 0) ? ACC : IDLE));
      mon(0, sv0, {sf0, sum0});
      mon(1, sv1, {20'd0, sf1, sum1});
      mon(2, sv2, {20'd0, sf2, sum2});
      mon(3, sv3, {20'd0, sf3, sum3});
    end
  end

  initial begin
    logic [15:0] extremes [4];
    logic        e, c, v;
    logic [15:0] a, w;
    extremes = '{16'h8080, 16'h7F7F, 16'hFF80, 16'h0101};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum0", 64'(sum0), 64'd0);
    check("reset_sv0", 64'(sv0), 64'd0);
    check("reset_busy0", 64'(busy0), 64'd0);
    check("reset_state0", 64'(st0), 64'(IDLE));
    rst_n = 1'b1;
    idle(1);

    // k=4, 1..4 x 1..4 -> 30, two cycles after the last beat
    beat(1, 0, 1, 16'd1, 16'd1, 8'd4);
    check("echo_act", 64'(act_out0), 64'd1);
    beat(1, 0, 1, 16'd2, 16'd2, 8'd4);
    beat(1, 0, 1, 16'd3, 16'd3, 8'd4);
    beat(1, 0, 1, 16'd4, 16'd4, 8'd4);
    check("lat_not_yet", 64'(sv0), 64'd0);
    idle(1);
    check("lat_pulse", 64'(sv0), 64'd1);
    check("plan_sum30", 64'(sum0), 64'd30);
    idle(2);

    // signed: -3*7 + 5*-2 = -31
    beat(1, 0, 1, 16'hFFFD, 16'd7, 8'd2);
    beat(1, 0, 1, 16'd5, 16'hFFFE, 8'd2);
    idle(1);
    check("plan_neg31", 64'(sum0), 64'h0F_FFFF_FFE1);
    check("plan_neg31_sat", 64'(sf0), 64'd0);
    idle(2);

    // -128 * -128 x4 in 8-bit configs
    for (int i = 0; i < 4; i++) beat(1, 0, 1, 16'hFF80, 16'hFF80, 8'd4);
    idle(1);
    check("plan_sat_sum", 64'(sum1), 64'd32767);
    check("plan_sat_flag", 64'(sf1), 64'd1);
    check("plan_wrap_sum", 64'(sum2), 64'd0);
    check("plan_wrap_flag", 64'(sf2), 64'd0);
    check("plan_usat_sum", 64'(sum3), 64'hFFFF);
    check("plan_wide_sum", 64'(sum0), 64'd65536);
    idle(2);

    // back-to-back tiles k=2 then k=3, seven beats of 1
    for (int i = 0; i < 7; i++) beat(1, 0, 1, 16'd1, 16'd1, (i < 2) ? 8'd2 : 8'd3);
    check("b2b_busy", 64'(busy0), 64'd1);
    check("b2b_state", 64'(st0), 64'(ACC));
    beat(1, 0, 1, 16'd1, 16'd1, 8'd3);
    idle(3);

    // stall after beat 2, in_valid gap after beat 3
    beat(1, 0, 1, 16'd1, 16'd1, 8'd4);
    beat(1, 0, 1, 16'd2, 16'd2, 8'd4);
    for (int i = 0; i < 3; i++) beat(0, 0, 1, 16'd99, 16'd99, 8'd1);
    check("stall_frozen", 64'(act_out0), 64'd2);
    beat(1, 0, 1, 16'd3, 16'd3, 8'd4);
    beat(1, 0, 0, 16'd0, 16'd0, 8'd0);
    beat(1, 0, 0, 16'd0, 16'd0, 8'd0);
    beat(1, 0, 1, 16'd4, 16'd4, 8'd4);
    idle(3);
    check("stall_sum30", 64'(sum0), 64'd30);

    // clr discards a partial tile but keeps the last result
    beat(1, 0, 1, 16'd5, 16'd5, 8'd4);
    beat(1, 0, 1, 16'd6, 16'd6, 8'd4);
    beat(1, 1, 0, 16'd0, 16'd0, 8'd0);
    check("clr_hold", 64'(sum0), 64'd30);
    for (int i = 0; i < 4; i++) beat(1, 0, 1, 16'd1, 16'd1, 8'd4);
    idle(2);
    check("clr_fresh", 64'(sum0), 64'd4);

    // 40 beats of -32768^2 saturate the 36-bit accumulator
    for (int i = 0; i < 40; i++) beat(1, 0, 1, 16'h8000, 16'h8000, 8'd40);
    idle(2);
    check("wide_sat_sum", 64'(sum0), 64'h7_FFFF_FFFF);
    check("wide_sat_flag", 64'(sf0), 64'd1);

    for (int i = 0; i < 1500; i++) begin
      e = ($urandom_range(0, 99) < 85);
      c = e && ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 70);
      a = ($urandom_range(0, 3) == 0) ? extremes[$urandom_range(0, 3)] : 16'($urandom);
      w = ($urandom_range(0, 3) == 0) ? extremes[$urandom_range(0, 3)] : 16'($urandom);
      beat(e, c, v, a, w, 8'($urandom_range(0, 5)));
    end
    idle(4);

    // asynchronous reset in the middle of a tile
    beat(1, 0, 1, 16'd7, 16'd7, 8'd4);
    beat(1, 0, 1, 16'd7, 16'd7, 8'd4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", 64'(sum0), 64'd0);
    check("arst_busy", 64'(busy0), 64'd0);
    check("arst_act", 64'(act_out0), 64'd0);
    check("arst_valid", 64'(out_valid0), 64'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(5);

    check("drain_q0", 64'(q_size(0)), 64'd0);
    check("drain_q1", 64'(q_size(1)), 64'd0);
    check("drain_q2", 64'(q_size(2)), 64'd0);
    check("drain_q3", 64'(q_size(3)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
